lpddr2_cmd_encoder: RTL



---
 rtl/lpddr2_cmd_pkg.sv | 42 ++++
 rtl/lpddr2_cmd_encoder_if.sv | 38 +++
 rtl/lpddr2_ca_pack.sv | 100 ++++++++++
 rtl/lpddr2_cmd_encoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/lpddr2_cmd_pkg.sv
// Shared opcode/state encodings and CA low-nibble constants for the LPDDR2 command front-end.
package lpddr2_cmd_pkg;

  typedef enum logic [3:0] {
    OP_MRW  = 4'd0,
    OP_MRR  = 4'd1,
    OP_REF  = 4'd2,
    OP_PRE  = 4'd3,
    OP_ACT  = 4'd4,
    OP_WR   = 4'd5,
    OP_RD   = 4'd6,
    OP_BST  = 4'd7,
    OP_PD   = 4'd8,
    OP_SR   = 4'd9,
    OP_DPD  = 4'd10,
    OP_EXIT = 4'd11,
    OP_NOP  = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_LP_PD,
    ST_LP_SR,
    ST_LP_DPD
  } state_e;

  localparam logic [3:0] NIB_MRW = 4'h0;
  localparam logic [3:0] NIB_MRR = 4'h8;
  localparam logic [3:0] NIB_REF = 4'h4;
  localparam logic [3:0] NIB_PRE = 4'hB;
  localparam logic [3:0] NIB_ACT = 4'h2;
  localparam logic [3:0] NIB_WR  = 4'h1;
  localparam logic [3:0] NIB_RD  = 4'h5;
  localparam logic [3:0] NIB_BST = 4'h3;
  localparam logic [3:0] NIB_NOP = 4'h7;

  // Opcodes that put an ordinary chip-selected command on the CA bus while active.
  function automatic logic is_bus_cmd(input op_e op);
    return op inside {OP_MRW, OP_MRR, OP_REF, OP_PRE, OP_ACT, OP_WR, OP_RD, OP_BST, OP_NOP};
  endfunction

endpackage

// File: rtl/lpddr2_cmd_encoder_if.sv
// Command request channel plus the device-side pin bundle of the LPDDR2 command encoder.
interface lpddr2_cmd_encoder_if #(
  parameter int BA_BITS  = 3,
  parameter int CA_BITS  = 10,
  parameter int ROW_BITS = 15,
  parameter int COL_BITS = 12,
  parameter int GAP_BITS = 12
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [3:0]          cmd_op;
  logic [BA_BITS-1:0]  cmd_ba;
  logic [ROW_BITS-1:0] cmd_row;
  logic [COL_BITS-1:0] cmd_col;
  logic                cmd_flag;
  logic [7:0]          cmd_ma;
  logic [7:0]          cmd_mrdata;
  logic [GAP_BITS-1:0] cmd_gap;

  logic                cke;
  logic                cs_n;
  logic [CA_BITS-1:0]  ca_rise;
  logic [CA_BITS-1:0]  ca_fall;
  logic                rd_issue;
  logic                wr_issue;
  logic                cmd_err;
  logic                lp_active;

  modport master (
    output cmd_valid, cmd_op, cmd_ba, cmd_row, cmd_col, cmd_flag, cmd_ma, cmd_mrdata, cmd_gap,
    input  cmd_ready, cke, cs_n, ca_rise, ca_fall, rd_issue, wr_issue, cmd_err, lp_active
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ba, cmd_row, cmd_col, cmd_flag, cmd_ma, cmd_mrdata, cmd_gap,
    output cmd_ready, cke, cs_n, ca_rise, ca_fall, rd_issue, wr_issue, cmd_err, lp_active
  );
endinterface

// File: rtl/lpddr2_ca_pack.sv
// Combinational CA encoder: opcode plus address fields to both CA phases and the chip-select level.
module lpddr2_ca_pack
  import lpddr2_cmd_pkg::*;
#(
  parameter int BA_BITS  = 3,
  parameter int CA_BITS  = 10,
  parameter int ROW_BITS = 15,
  parameter int COL_BITS = 12
) (
  input  op_e                 op,
  input  logic [BA_BITS-1:0]  ba,
  input  logic [ROW_BITS-1:0] row,
  input  logic [COL_BITS-1:0] col,
  input  logic                flag,
  input  logic [7:0]          ma,
  input  logic [7:0]          mrdata,
  output logic [CA_BITS-1:0]  ca_rise,
  output logic [CA_BITS-1:0]  ca_fall,
  output logic                cs_n_cmd
);

  // Column bit 0 is implied by the burst alignment and never travels on CA.
  logic unused_col0;
  assign unused_col0 = col[0];

  always_comb begin
    ca_rise  = '1;
    ca_fall  = '1;
    cs_n_cmd = 1'b1;
    case (op)
      OP_MRW: begin
        ca_rise  = {ma[5:0], NIB_MRW};
        ca_fall  = {mrdata, ma[7:6]};
        cs_n_cmd = 1'b0;
      end
      OP_MRR: begin
        ca_rise  = {ma[5:0], NIB_MRR};
        ca_fall  = {8'h0, ma[7:6]};
        cs_n_cmd = 1'b0;
      end
      OP_REF: begin
        ca_rise  = {6'h0, flag, NIB_REF[2:0]};
        ca_fall  = '0;
        cs_n_cmd = 1'b0;
      end
      OP_PRE: begin
        ca_rise  = {ba, 2'b00, flag, NIB_PRE};
        ca_fall  = '0;
        cs_n_cmd = 1'b0;
      end
      OP_ACT: begin
        ca_rise  = {ba, row[12:8], NIB_ACT[1:0]};
        ca_fall  = {row[14:13], row[7:0]};
        cs_n_cmd = 1'b0;
      end
      OP_WR: begin
        ca_rise  = {ba, col[2:1], 2'b00, NIB_WR[2:0]};
        ca_fall  = {col[11:3], flag};
        cs_n_cmd = 1'b0;
      end
      OP_RD: begin
        ca_rise  = {ba, col[2:1], 2'b00, NIB_RD[2:0]};
        ca_fall  = {col[11:3], flag};
        cs_n_cmd = 1'b0;
      end
      OP_BST: begin
        ca_rise  = {6'h0, NIB_BST};
        ca_fall  = '0;
        cs_n_cmd = 1'b0;
      end
      OP_NOP: begin
        ca_rise  = {7'h0, NIB_NOP[2:0]};
        ca_fall  = {7'h0, NIB_NOP[2:0]};
        cs_n_cmd = 1'b0;
      end
      // Low-power entries: SR and DPD are chip-selected with cke falling, PD is not.
      OP_SR: begin
        ca_rise  = {7'h0, 3'h4};
        ca_fall  = '0;
        cs_n_cmd = 1'b0;
      end
      OP_DPD: begin
        ca_rise  = {7'h0, 3'h3};
        ca_fall  = '0;
        cs_n_cmd = 1'b0;
      end
      OP_PD: begin
        ca_rise  = '0;
        ca_fall  = '0;
        cs_n_cmd = 1'b1;
      end
      default: begin
        ca_rise  = '1;
        ca_fall  = '1;
        cs_n_cmd = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lpddr2_cmd_encoder.sv
// LPDDR2 command front-end: handshake, inter-command gap, power-state FSM and registered pin drive.
module lpddr2_cmd_encoder
  import lpddr2_cmd_pkg::*;
#(
  parameter int BA_BITS  = 3,
  parameter int CA_BITS  = 10,
  parameter int ROW_BITS = 15,
  parameter int COL_BITS = 12,
  parameter int GAP_BITS = 12,
  parameter int CKE_MIN  = 3
) (
  input logic                  ck,
  input logic                  rst,
  lpddr2_cmd_encoder_if.slave  bus
);

  localparam int LP_W = $clog2(CKE_MIN + 1);

  state_e              state_q, state_d;
  logic [GAP_BITS-1:0] gap_q, gap_d;
  logic [LP_W-1:0]     lp_cnt_q, lp_cnt_d;
  logic                cke_q, cke_d;
  logic                cs_n_q, cs_n_d;
  logic [CA_BITS-1:0]  ca_rise_q, ca_rise_d;
  logic [CA_BITS-1:0]  ca_fall_q, ca_fall_d;
  logic                rd_issue_q, rd_issue_d;
  logic                wr_issue_q, wr_issue_d;
  logic                cmd_err_q, cmd_err_d;
  logic                lp_active_q, lp_active_d;

  op_e                 op;
  logic [CA_BITS-1:0]  pk_rise, pk_fall;
  logic                pk_cs_n;
  logic                in_lp, ready, accept;

  assign op     = op_e'(bus.cmd_op);
  assign in_lp  = (state_q != ST_ACTIVE);
  // Exit from a low-power state is held off until cke has been low long enough.
  assign ready  = (gap_q == '0) && (!in_lp || lp_cnt_q >= LP_W'(CKE_MIN - 1));
  assign accept = bus.cmd_valid && ready;

  lpddr2_ca_pack #(
    .BA_BITS (BA_BITS),
    .CA_BITS (CA_BITS),
    .ROW_BITS(ROW_BITS),
    .COL_BITS(COL_BITS)
  ) u_ca_pack (
    .op      (op),
    .ba      (bus.cmd_ba),
    .row     (bus.cmd_row),
    .col     (bus.cmd_col),
    .flag    (bus.cmd_flag),
    .ma      (bus.cmd_ma),
    .mrdata  (bus.cmd_mrdata),
    .ca_rise (pk_rise),
    .ca_fall (pk_fall),
    .cs_n_cmd(pk_cs_n)
  );

  always_comb begin
    // NOTE: every _d is given a default before any branch so no latch can be inferred.
    state_d    = state_q;
    gap_d      = (gap_q != '0) ? gap_q - GAP_BITS'(1) : gap_q;
    lp_cnt_d   = (in_lp && lp_cnt_q < LP_W'(CKE_MIN)) ? lp_cnt_q + LP_W'(1) : lp_cnt_q;
    rd_issue_d = 1'b0;
    wr_issue_d = 1'b0;
    cmd_err_d  = 1'b0;
    if (in_lp) begin
      cke_d     = 1'b0;
      cs_n_d    = 1'b1;
      ca_rise_d = ca_rise_q;
      ca_fall_d = ca_fall_q;
    end else begin
      cke_d     = 1'b1;
      cs_n_d    = 1'b1;
      ca_rise_d = '1;
      ca_fall_d = '1;
    end

    if (accept) begin
      gap_d = bus.cmd_gap;
      if (in_lp) begin
        if (op == OP_EXIT) begin
          state_d   = ST_ACTIVE;
          lp_cnt_d  = '0;
          cke_d     = 1'b1;
          ca_rise_d = '1;
          ca_fall_d = '1;
        end else begin
          cmd_err_d = 1'b1;
        end
      end else begin
        case (op)
          OP_PD, OP_SR, OP_DPD: begin
            state_d   = (op == OP_PD) ? ST_LP_PD : (op == OP_SR) ? ST_LP_SR : ST_LP_DPD;
            lp_cnt_d  = '0;
            cke_d     = 1'b0;
            cs_n_d    = pk_cs_n;
            ca_rise_d = pk_rise;
            ca_fall_d = pk_fall;
          end
          default: begin
            if (is_bus_cmd(op)) begin
              cs_n_d     = pk_cs_n;
              ca_rise_d  = pk_rise;
              ca_fall_d  = pk_fall;
              rd_issue_d = (op == OP_RD) || (op == OP_MRR);
              wr_issue_d = (op == OP_WR);
            end else begin
              cmd_err_d = 1'b1;
            end
          end
        endcase
      end
    end
    lp_active_d = (state_d != ST_ACTIVE);
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LP_PD;
      gap_q       <= '0;
      lp_cnt_q    <= '0;
      cke_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      ca_rise_q   <= '0;
      ca_fall_q   <= '0;
      rd_issue_q  <= 1'b0;
      wr_issue_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      lp_active_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      gap_q       <= gap_d;
      lp_cnt_q    <= lp_cnt_d;
      cke_q       <= cke_d;
      cs_n_q      <= cs_n_d;
      ca_rise_q   <= ca_rise_d;
      ca_fall_q   <= ca_fall_d;
      rd_issue_q  <= rd_issue_d;
      wr_issue_q  <= wr_issue_d;
      cmd_err_q   <= cmd_err_d;
      lp_active_q <= lp_active_d;
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.cke       = cke_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.ca_rise   = ca_rise_q;
  assign bus.ca_fall   = ca_fall_q;
  assign bus.rd_issue  = rd_issue_q;
  assign bus.wr_issue  = wr_issue_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.lp_active = lp_active_q;

endmodule
